// File: rtl/vout_quadencoderz.sv
// vout_quadencoderz: quadrature encoder emulator. Turns a signed edge-period
// command into A/B/Z encoder waveforms and keeps the signed edge count that a
// decoder watching the same lines would accumulate.
//
// Build option: define VOUT_QUADENCODERZ_GATED_INDEX_EN to narrow the index
// pulse to the single A=0,B=0 state at phase 0. Left undefined, the index is
// high for the whole first quadrature cycle (phase 0..3) of each revolution.
//
// Parameters:
//   PPR        lines per revolution (4*PPR quadrature edges per rev), 1..2^24
//   MIN_PERIOD minimum clocks between edges; smaller nonzero commands clamp up
//
// Ports:
//   clk     in   system clock
//   reset   in   asynchronous reset, active-high
//   period  in   signed clocks per edge; sign = direction, 0 = stopped
//   zero    in   synchronous clear of position, phase and timer
//   quadA   out  encoder channel A (registered)
//   quadB   out  encoder channel B (registered)
//   quadZ   out  index channel (registered)
//   pos     out  signed edge count (registered)
module vout_quadencoderz #(
  parameter int unsigned PPR        = 1024,
  parameter int unsigned MIN_PERIOD = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [31:0] period,
  input  logic               zero,
  output logic               quadA,
  output logic               quadB,
  output logic               quadZ,
  output logic signed [31:0] pos
);

  localparam int unsigned PH_MAX = 4 * PPR;
  localparam int unsigned PH_W   = $clog2(PH_MAX);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PH_MAX - 1);
  localparam logic [31:0]     MIN_MAG = 32'(MIN_PERIOD);

  logic [31:0]        timer_q, timer_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic signed [31:0] pos_q, pos_d;
  logic               quad_a_q, quad_a_d;
  logic               quad_b_q, quad_b_d;
  logic               quad_z_q, quad_z_d;

  logic [31:0] mag_raw;
  logic [31:0] mag;
  logic        step;

  // Magnitude of the command as unsigned; -2^31 maps to 2^31 naturally.
  always_comb begin
    mag_raw = period[31] ? (~period + 32'd1) : period;
    mag     = mag_raw;
    if ((mag_raw != 32'd0) && (mag_raw < MIN_MAG)) begin
      mag = MIN_MAG;
    end
    // >= so a period shortened below the running count fires next cycle.
    step = (mag != 32'd0) && (timer_q >= (mag - 32'd1));
  end

  // Timer, phase and position next-state; zero outranks a coincident step.
  always_comb begin
    timer_d = timer_q;
    phase_d = phase_q;
    pos_d   = pos_q;
    if (zero) begin
      timer_d = 32'd0;
      phase_d = '0;
      pos_d   = 32'sd0;
    end else if (mag == 32'd0) begin
      timer_d = 32'd0;
    end else if (step) begin
      timer_d = 32'd0;
      if (period[31]) begin
        phase_d = (phase_q == '0) ? PH_LAST : (phase_q - PH_W'(1));
        pos_d   = pos_q - 32'sd1;
      end else begin
        phase_d = (phase_q == PH_LAST) ? '0 : (phase_q + PH_W'(1));
        pos_d   = pos_q + 32'sd1;
      end
    end else begin
      timer_d = timer_q + 32'd1;
    end
  end

  // Pin decode from the next phase so pins move on the same edge as phase.
  always_comb begin
    quad_a_d = 1'b0;
    quad_b_d = 1'b0;
    case (phase_d[1:0])
      2'd0:    begin quad_a_d = 1'b0; quad_b_d = 1'b0; end
      2'd1:    begin quad_a_d = 1'b1; quad_b_d = 1'b0; end
      2'd2:    begin quad_a_d = 1'b1; quad_b_d = 1'b1; end
      default: begin quad_a_d = 1'b0; quad_b_d = 1'b1; end
    endcase
`ifdef VOUT_QUADENCODERZ_GATED_INDEX_EN
    quad_z_d = (phase_d == '0);
`else
    quad_z_d = (phase_d <= PH_W'(3));
`endif
  end

  // State and output registers; reset lands at index with no partial edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q  <= 32'd0;
      phase_q  <= '0;
      pos_q    <= 32'sd0;
      quad_a_q <= 1'b0;
      quad_b_q <= 1'b0;
      quad_z_q <= 1'b1;
    end else begin
      timer_q  <= timer_d;
      phase_q  <= phase_d;
      pos_q    <= pos_d;
      quad_a_q <= quad_a_d;
      quad_b_q <= quad_b_d;
      quad_z_q <= quad_z_d;
    end
  end

  assign quadA = quad_a_q;
  assign quadB = quad_b_q;
  assign quadZ = quad_z_q;
  assign pos   = pos_q;

endmodule
